// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game sequencer with board registers, turn FSM and timeout forfeit

module check_win (
    input  logic [8:0] sym,
    input  logic [8:0] val,
    output logic [1:0] gs
);
    logic [8:0] xs;
    logic [8:0] os;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign xs = sym & val;
    assign os = ~sym & val;
    assign gs = {has_line(os), has_line(xs)};
endmodule

module ttt_game_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       first_player,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic [8:0] sym,
    output logic [8:0] val,
    output logic       turn,
    output logic       ready,
    output logic       move_ack,
    output logic       move_err,
    output logic       x_win,
    output logic       o_win,
    output logic       draw,
    output logic       timeout,
    output logic       game_over
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_X_TURN = 3'd1;
    localparam logic [2:0] S_O_TURN = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [3:0]       move_cnt;
    logic [CNT_W-1:0] tcnt;
    logic [1:0]       gs;
    logic [15:0]      pos_dec;
    logic [8:0]       cell_bit;
    logic             pos_ok;
    logic             legal;
    logic             in_turn;
    logic             tmo_hit;

    check_win u_check_win (
        .sym (sym),
        .val (val),
        .gs  (gs)
    );

    assign pos_dec   = 16'd1 << move_pos;
    assign cell_bit  = pos_dec[8:0];
    assign pos_ok    = (move_pos <= 4'd8);
    assign legal     = pos_ok && ((val & cell_bit) == 9'd0);
    assign in_turn   = (state == S_X_TURN) || (state == S_O_TURN);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST);
    assign ready     = in_turn;
    assign game_over = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sym      <= 9'd0;
            val      <= 9'd0;
            turn     <= 1'b0;
            move_cnt <= 4'd0;
            tcnt     <= '0;
            move_ack <= 1'b0;
            move_err <= 1'b0;
            x_win    <= 1'b0;
            o_win    <= 1'b0;
            draw     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            // new_game wins over everything, including a same-cycle move
            if (new_game) begin
                sym      <= 9'd0;
                val      <= 9'd0;
                move_cnt <= 4'd0;
                tcnt     <= '0;
                x_win    <= 1'b0;
                o_win    <= 1'b0;
                draw     <= 1'b0;
                timeout  <= 1'b0;
                turn     <= first_player;
                state    <= first_player ? S_X_TURN : S_O_TURN;
            end else begin
                case (state)
                    S_X_TURN, S_O_TURN: begin
                        if (move_valid && legal) begin
                            val      <= val | cell_bit;
                            sym      <= turn ? (sym | cell_bit) : (sym & ~cell_bit);
                            move_cnt <= move_cnt + 4'd1;
                            move_ack <= 1'b1;
                            tcnt     <= '0;
                            state    <= S_CHECK;
                        end else begin
                            if (move_valid) begin
                                move_err <= 1'b1;
                            end
                            // the idle player forfeits; the other side takes the win
                            if (tmo_hit) begin
                                timeout <= 1'b1;
                                o_win   <= turn;
                                x_win   <= ~turn;
                                tcnt    <= '0;
                                state   <= S_DONE;
                            end else if (TIMEOUT_CYCLES != 0) begin
                                tcnt <= tcnt + CNT_W'(1);
                            end
                        end
                    end
                    S_CHECK: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                        end
                        if (gs[0]) begin
                            x_win <= 1'b1;
                            state <= S_DONE;
                        end else if (gs[1]) begin
                            o_win <= 1'b1;
                            state <= S_DONE;
                        end else if (move_cnt == 4'd9) begin
                            draw  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            turn  <= ~turn;
                            tcnt  <= '0;
                            state <= turn ? S_O_TURN : S_X_TURN;
                        end
                    end
                    S_IDLE, S_DONE: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (move_valid) begin
                            move_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - randomized and directed bench for ttt_game_ctrl against a game-rule model

module tb_ttt_game_ctrl;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       first_player = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic [8:0] sym;
    logic [8:0] val;
    logic       turn;
    logic       ready;
    logic       move_ack;
    logic       move_err;
    logic       x_win;
    logic       o_win;
    logic       draw;
    logic       timeout;
    logic       game_over;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .first_player (first_player),
        .move_valid   (move_valid),
        .move_pos     (move_pos),
        .sym          (sym),
        .val          (val),
        .turn         (turn),
        .ready        (ready),
        .move_ack     (move_ack),
        .move_err     (move_err),
        .x_win        (x_win),
        .o_win        (o_win),
        .draw         (draw),
        .timeout      (timeout),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // game model: cell 0 empty, 1 X, 2 O; phase 0 idle, 1 playing, 2 judging, 3 over
    int m_cell [9];
    int m_phase, m_moves, m_idle;
    bit m_turn, m_ack, m_err, m_xw, m_ow, m_dr, m_to;
    int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit owns_line(int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[ln[l][0]] == who && m_cell[ln[l][1]] == who && m_cell[ln[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_phase = 0; m_moves = 0; m_idle = 0;
        m_turn = 0; m_ack = 0; m_err = 0; m_xw = 0; m_ow = 0; m_dr = 0; m_to = 0;
    endtask

    task automatic model_step(input bit r, input bit ng, input bit fp, input bit mv, input int mp);
        m_ack = 0;
        m_err = 0;
        if (r) begin
            model_reset();
        end else if (ng) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            m_moves = 0; m_xw = 0; m_ow = 0; m_dr = 0; m_to = 0;
            m_turn = fp; m_phase = 1; m_idle = 0;
        end else if (m_phase == 1) begin
            if (mv && mp <= 8 && m_cell[mp] == 0) begin
                m_cell[mp] = m_turn ? 1 : 2;
                m_moves++;
                m_ack = 1;
                m_phase = 2;
            end else begin
                if (mv) m_err = 1;
                if (m_idle == TO - 1) begin
                    m_phase = 3; m_to = 1;
                    if (m_turn) m_ow = 1; else m_xw = 1;
                end else begin
                    m_idle++;
                end
            end
        end else if (m_phase == 2) begin
            if (mv) m_err = 1;
            if (owns_line(1)) begin m_xw = 1; m_phase = 3; end
            else if (owns_line(2)) begin m_ow = 1; m_phase = 3; end
            else if (m_moves == 9) begin m_dr = 1; m_phase = 3; end
            else begin m_turn = ~m_turn; m_phase = 1; m_idle = 0; end
        end else begin
            if (mv) m_err = 1;
        end
    endtask

    function automatic logic [26:0] model_outs();
        logic [8:0] s, v;
        s = '0; v = '0;
        for (int i = 0; i < 9; i++) begin
            v[i] = (m_cell[i] != 0);
            s[i] = (m_cell[i] == 1);
        end
        return {s, v, m_turn, m_phase == 1, m_ack, m_err, m_xw, m_ow, m_dr, m_to, m_phase == 3};
    endfunction

    function automatic logic [26:0] dut_outs();
        return {sym, val, turn, ready, move_ack, move_err, x_win, o_win, draw, timeout, game_over};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("outputs", 32'(dut_outs()), 32'(model_outs()));
    end

    task automatic step(input bit ng, input bit fp, input bit mv, input int mp);
        new_game = ng; first_player = fp; move_valid = mv; move_pos = 4'(mp);
        @(posedge clk);
        model_step(rst, ng, fp, mv, mp);
        @(negedge clk);
        #1;
    endtask

    task automatic play(input int pos);
        step(0, 0, 1, pos);
        step(0, 0, 0, 0);
    endtask

    int acks;
    int n;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        model_reset();
        @(negedge clk); #1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 0;
        step(0, 0, 0, 0);
        check("reset_outputs", 32'(dut_outs()), 32'd0);

        // X wins on the top row
        step(1, 1, 0, 0);
        acks = 0;
        foreach (draw_seq[k]) begin end
        begin
            int seq [5] = '{0, 3, 1, 4, 2};
            foreach (seq[k]) begin
                step(0, 0, 1, seq[k]);
                if (move_ack) acks++;
                step(0, 0, 0, 0);
            end
        end
        check("win_acks", 32'(acks), 32'd5);
        check("win_x", 32'(x_win), 32'd1);
        check("win_over", 32'(game_over), 32'd1);
        check("win_sym", 32'(sym), 32'h007);
        check("win_val", 32'(val), 32'h01F);

        // rejects leave the board and turn alone
        step(1, 1, 0, 0);
        play(4);
        step(0, 0, 1, 4);
        check("err_occupied", 32'(move_err), 32'd1);
        step(0, 0, 1, 9);
        check("err_range", 32'(move_err), 32'd1);
        check("err_board", 32'({sym, val}), 32'({9'h010, 9'h010}));
        check("err_turn_ready", 32'({turn, ready}), 32'b01);

        // full board without a line
        step(1, 1, 0, 0);
        foreach (draw_seq[k]) play(draw_seq[k]);
        check("draw_flags", 32'({draw, x_win, o_win}), 32'b100);
        check("draw_board", 32'({sym, val}), 32'({9'h18D, 9'h1FF}));

        // O starts and never moves
        step(1, 0, 0, 0);
        n = 0;
        while (!game_over && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO));
        check("timeout_flags", 32'({timeout, x_win, o_win, game_over}), 32'b1101);

        // new_game beats a same-cycle move
        step(1, 1, 0, 0);
        play(0);
        step(1, 1, 1, 5);
        check("ng_no_handshake", 32'({move_ack, move_err}), 32'd0);
        check("ng_cleared", 32'(val), 32'd0);
        step(0, 0, 1, 0);
        check("ng_followup_ack", 32'(move_ack), 32'd1);

        // asynchronous reset while judging
        step(1, 1, 0, 0);
        step(0, 0, 1, 2);
        #1 rst = 1;
        #1;
        check("async_rst_outputs", 32'(dut_outs()), 32'd0);
        model_reset();
        step(0, 0, 0, 0);
        rst = 0;

        for (int c = 0; c < 4000; c++) begin
            bit ng, mv;
            int mp;
            ng = ($urandom_range(0, 39) == 0);
            mv = ($urandom_range(0, 9) < 5);
            mp = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 9);
            step(ng, 1'($urandom), mv, mp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
